// File: rtl/float_div_if.sv
// Operand/result handshake bundle for float_div: valid/ready in, valid/ready out.
interface float_div_if #(
    parameter int unsigned Width = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] c;
    logic             div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, div_by_zero
    );
endinterface

// File: rtl/float_div.sv
// Sequential single-precision divider c = a / b, one quotient bit per cycle (restoring).
// Define FLOAT_DIV_ROUND_EN for round-to-nearest-even (one extra CALC cycle); default truncates.
module float_div #(
    parameter int unsigned E     = 8,
    parameter int unsigned M     = 23,
    parameter int unsigned Width = 1 + E + M
) (
    input logic       clk,
    input logic       rst_n,
    float_div_if.slave bus
);

    localparam int unsigned EW = E + 2;
    localparam int unsigned RW = M + 2;
    localparam int unsigned MH = M + 1;
`ifdef FLOAT_DIV_ROUND_EN
    localparam int unsigned NIter = M + 3;
`else
    localparam int unsigned NIter = M + 2;
`endif
    localparam int unsigned QW     = NIter;
    localparam int unsigned CW     = $clog2(NIter + 1);
    localparam int unsigned Bias   = (1 << (E - 1)) - 1;
    localparam int unsigned ExpMax = (1 << E) - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] NORM = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [Width-1:0] QNan = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [QW-1:0]    q_q, q_d;
    logic [MH-1:0]    bm_q, bm_d;
    logic [EW-1:0]    ediff_q, ediff_d;
    logic             cs_q, cs_d;
    logic [Width-1:0] c_q, c_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic             a_s, b_s;
    logic [E-1:0]     a_e, b_e;
    logic [M-1:0]     a_m, b_m;
    logic             a_max, b_max, a_zero, b_zero;

    logic [M-1:0]     mant;
    logic [EW-1:0]    exp_n;
`ifdef FLOAT_DIV_ROUND_EN
    logic             guard;
    logic             sticky;
    logic [MH-1:0]    mant_r;
`endif

    assign {a_s, a_e, a_m} = bus.a;
    assign {b_s, b_e, b_m} = bus.b;
    assign a_max  = &a_e;
    assign b_max  = &b_e;
    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        q_d         = q_q;
        bm_d        = bm_q;
        ediff_d     = ediff_q;
        cs_d        = cs_q;
        c_d         = c_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        mant        = '0;
        exp_n       = '0;
`ifdef FLOAT_DIV_ROUND_EN
        guard       = 1'b0;
        sticky      = 1'b0;
        mant_r      = '0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    cs_d       = a_s ^ b_s;
                    ediff_d    = EW'(a_e) - EW'(b_e) + EW'(Bias);
                    bm_d       = {1'b1, b_m};
                    rem_d      = RW'({1'b1, a_m});
                    q_d        = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                    // Specials bypass the iteration and are ready on the next cycle
                    if (a_max || b_max) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        c_d         = QNan;
                        dbz_d       = 1'b0;
                    end else if (b_zero) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        c_d         = a_zero ? QNan : {a_s ^ b_s, {E{1'b1}}, {M{1'b0}}};
                        dbz_d       = 1'b1;
                    end else if (a_zero) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        c_d         = {a_s ^ b_s, {(E+M){1'b0}}};
                        dbz_d       = 1'b0;
                    end
                end
            end

            CALC: begin
                if (rem_q >= RW'(bm_q)) begin
                    q_d   = {q_q[QW-2:0], 1'b1};
                    rem_d = RW'((rem_q - RW'(bm_q)) << 1);
                end else begin
                    q_d   = {q_q[QW-2:0], 1'b0};
                    rem_d = RW'(rem_q << 1);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NIter - 1)) begin
                    state_d = NORM;
                end
            end

            NORM: begin
`ifdef FLOAT_DIV_ROUND_EN
                if (q_q[QW-1]) begin
                    mant   = q_q[QW-2:2];
                    guard  = q_q[1];
                    sticky = q_q[0] | (rem_q != '0);
                    exp_n  = ediff_q;
                end else begin
                    mant   = q_q[QW-3:1];
                    guard  = q_q[0];
                    sticky = (rem_q != '0);
                    exp_n  = ediff_q - EW'(1);
                end
                // Nearest-even; a carry out of the fraction bumps the exponent
                mant_r = {1'b0, mant} + MH'(guard & (sticky | mant[0]));
                if (mant_r[M]) begin
                    exp_n = exp_n + EW'(1);
                end
                mant = mant_r[M-1:0];
`else
                if (q_q[QW-1]) begin
                    mant  = q_q[QW-2:1];
                    exp_n = ediff_q;
                end else begin
                    mant  = q_q[QW-3:0];
                    exp_n = ediff_q - EW'(1);
                end
`endif
                if (!exp_n[EW-1] && (exp_n >= EW'(ExpMax))) begin
                    c_d = {cs_q, {E{1'b1}}, {M{1'b0}}};
                end else if (exp_n[EW-1] || (exp_n == '0)) begin
                    c_d = {cs_q, {(E+M){1'b0}}};
                end else begin
                    c_d = {cs_q, exp_n[E-1:0], mant};
                end
                dbz_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            bm_q        <= '0;
            ediff_q     <= '0;
            cs_q        <= 1'b0;
            c_q         <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            bm_q        <= bm_d;
            ediff_q     <= ediff_d;
            cs_q        <= cs_d;
            c_q         <= c_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.c           = c_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_float_div.sv
// Scoreboard bench for float_div: driver queues expected results, negedge monitor checks them.
module tb_float_div;

    localparam int M = 23;
`ifdef FLOAT_DIV_ROUND_EN
    localparam int LatNom = M + 4;
    localparam logic [31:0] OneThird = 32'h3EAAAAAB;
`else
    localparam int LatNom = M + 3;
    localparam logic [31:0] OneThird = 32'h3EAAAAAA;
`endif
    // Specials are registered on the accepting edge itself: high in the cycle right after the handshake
    localparam int LatSpc = 0;
    localparam int Tput   = LatNom + 2;

    typedef struct {
        logic [31:0] c;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   hs = 0;
    bit   pending = 1'b0;
    exp_t cur;
    exp_t sb[$];

    float_div_if #(.Width(32)) bus ();

    float_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endfunction

    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] ec,
                        input logic ed, input int lat, output int acc);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        acc = -1;
        @(posedge clk); #1;
        bus.a = va;
        bus.b = vb;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            fail("accept_timeout");
            bus.in_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        e.c = ec; e.dbz = ed; e.lat = lat; e.acc = acc;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !pending) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail({name, "_result_timeout"});
    endtask

    task automatic run(input string name, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] ec, input logic ed, input int lat);
        int acc;
        send(va, vb, ec, ed, lat, acc);
        wait_done(name);
    endtask

    // Monitor: check each result when out_valid rises, then its stability until the handshake
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
            end else if (bus.out_valid) begin
                if (!pending) begin
                    pending = 1'b1;
                    if (sb.size() == 0) begin
                        fail("unexpected_result");
                        cur.c = bus.c;
                    end else begin
                        cur = sb.pop_front();
                        chk("c", bus.c, cur.c);
                        chk("div_by_zero", 32'(bus.div_by_zero), 32'(cur.dbz));
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                end else begin
                    chk("c_hold", bus.c, cur.c);
                end
                if (bus.out_ready) begin
                    pending = 1'b0;
                    hs++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int acc2;
        int hs0;
        bit ok;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_c", bus.c, 32'h0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;

        run("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LatNom);
        run("one_third",  32'h3F800000, 32'h40400000, OneThird,     1'b0, LatNom);
        run("neg",        32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, LatNom);
        run("half",       32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, LatNom);
        run("two",        32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, LatNom);
        run("div_zero",   32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, LatSpc);
        run("neg_div_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, LatSpc);
        run("zero_zero",  32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, LatSpc);
        run("neg_zero",   32'h80000000, 32'h40000000, 32'h80000000, 1'b0, LatSpc);
        run("nan_in",     32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, LatSpc);
        run("overflow",   32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, LatNom);
        run("underflow",  32'h00800000, 32'h40000000, 32'h00000000, 1'b0, LatNom);

        // Back-to-back issue with out_ready held high
        send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LatNom, acc);
        send(32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, LatNom, acc2);
        chk("throughput", 32'(acc2 - acc), 32'(Tput));
        wait_done("throughput");

        // Backpressure: result held in DONE, input pulses ignored
        bus.out_ready = 1'b0;
        send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LatNom, acc);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("bp_out_valid_timeout");
        hs0 = hs;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            bus.a = 32'h3F800000;
            bus.b = 32'h00000000;
            bus.in_valid = (i % 2 == 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_handshakes", 32'(hs - hs0), 32'd1);
        chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_no_ghost", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of CALC
        send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LatNom, acc);
        repeat (5) @(posedge clk);
        #1;
        chk("calc_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LatNom);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
